matrix_nms: RTL and testbench

MATRIX_NMS -- requirements
Module: matrix_nms

---
 rtl/canny_pkg.sv | 12 +
 rtl/nms_line_buffer.sv | 33 +++
 rtl/matrix_nms.sv | 104 ++++++++++
 tb/tb_matrix_nms.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared Canny pipeline definitions: gradient direction codes and pixel/direction widths.
package canny_pkg;

    localparam int PIX_W = 8;
    localparam int DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_H    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_D45  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_V    = 2'd2;
    localparam logic [DIR_W-1:0] DIR_D135 = 2'd3;

endpackage

// File: rtl/nms_line_buffer.sv
// One-line delay for the NMS window: returns the word written DEPTH enables earlier.
module nms_line_buffer #(
    parameter logic [10:0] DEPTH = 11'd250,
    parameter int          DW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int AW = (DEPTH > 11'd1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == AW'(DEPTH - 11'd1)) ? '0 : ptr + AW'(1);
    end

    // Storage is deliberately unreset; stale words only ever feed border outputs.
    always_ff @(posedge clk) begin
        if (en)
            mem[ptr] <= din;
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/matrix_nms.sv
// Canny non-maximum suppression over a 3x3 raster window.
// Optional low-magnitude floor enabled by defining NMS_LOW_THRESH_EN.
module matrix_nms
    import canny_pkg::*;
#(
    parameter logic [10:0]      PIC_WIDTH  = 11'd250,
    parameter logic [10:0]      PIC_HEIGHT = 11'd250,
    parameter int               WIDTH      = PIX_W,
    parameter logic [WIDTH-1:0] LOW_THRESH = 8'd20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [WIDTH+DIR_W-1:0] din,
    output logic                   valid_out,
    output logic [WIDTH-1:0]       dout
);

    localparam int PW = WIDTH + DIR_W;

    logic [10:0]                col, row;
    logic [PW-1:0]              lb1_q, lb2_q;
    // win[row][col]: row 0 is the oldest line (up), col 2 the newest column (right)
    logic [2:0][2:0][PW-1:0]    win;
    logic                       s_vld, s_border;
    logic [WIDTH-1:0]           cmag, nb_a, nb_b, nms_out;
    logic [DIR_W-1:0]           cdir;
    logic                       keep;

    nms_line_buffer #(.DEPTH(PIC_WIDTH), .DW(PW)) u_lb1 (
        .clk (clk),
        .rst (rst),
        .en  (valid_in),
        .din (din),
        .dout(lb1_q)
    );

    nms_line_buffer #(.DEPTH(PIC_WIDTH), .DW(PW)) u_lb2 (
        .clk (clk),
        .rst (rst),
        .en  (valid_in),
        .din (lb1_q),
        .dout(lb2_q)
    );

    function automatic logic [WIDTH-1:0] mag_of(input logic [PW-1:0] px);
        return px[PW-1:DIR_W];
    endfunction

    always_comb begin
        cmag = mag_of(win[1][1]);
        cdir = win[1][1][DIR_W-1:0];
        nb_a = '0;
        nb_b = '0;
        case (cdir)
            DIR_H:    begin nb_a = mag_of(win[1][0]); nb_b = mag_of(win[1][2]); end
            DIR_V:    begin nb_a = mag_of(win[0][1]); nb_b = mag_of(win[2][1]); end
            DIR_D45:  begin nb_a = mag_of(win[0][2]); nb_b = mag_of(win[2][0]); end
            DIR_D135: begin nb_a = mag_of(win[0][0]); nb_b = mag_of(win[2][2]); end
            default:  begin nb_a = '0; nb_b = '0; end
        endcase
        keep = (cmag >= nb_a) && (cmag >= nb_b);
`ifdef NMS_LOW_THRESH_EN
        if (cmag < LOW_THRESH)
            keep = 1'b0;
`endif
        nms_out = (keep && !s_border) ? cmag : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win       <= '0;
            s_vld     <= 1'b0;
            s_border  <= 1'b0;
            valid_out <= 1'b0;
            dout      <= '0;
        end else begin
            // Input (r,c) centres the window on (r-1,c-1); border centres output 0
            s_vld    <= valid_in && (row != 11'd0) && (col != 11'd0);
            s_border <= (row == 11'd1) || (col == 11'd1);
            if (valid_in) begin
                if (col == PIC_WIDTH - 11'd1) begin
                    col <= '0;
                    row <= (row == PIC_HEIGHT - 11'd1) ? 11'd0 : row + 11'd1;
                end else begin
                    col <= col + 11'd1;
                end
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_q;
                win[1][2] <= lb1_q;
                win[2][2] <= din;
            end
            valid_out <= s_vld;
            if (s_vld)
                dout <= nms_out;
        end
    end

endmodule

// File: tb/tb_matrix_nms.sv
// Self-checking bench for matrix_nms on an 8x8 frame: directed tables, random frames, stalls, resets.
module tb_matrix_nms;

    localparam logic [10:0] PW = 11'd8;
    localparam logic [10:0] PH = 11'd8;
    localparam int W  = 8;
    localparam int NO = 7;
    localparam int NPIX = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [W+1:0] din = '0;
    logic         valid_out;
    logic [W-1:0] dout;

    matrix_nms #(.PIC_WIDTH(PW), .PIC_HEIGHT(PH), .WIDTH(W), .LOW_THRESH(8'd20)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .din      (din),
        .valid_out(valid_out),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fm [8][8];
    int fd [8][8];
    int got [$];
    int saved [$];

    typedef struct {
        int kind;
        int pr;
        int pc;
        int expv;
    } vec_t;
    vec_t tbl [$];

    always @(negedge clk) begin
        if (!rst && valid_out)
            got.push_back(int'(dout));
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int mag_at(int r, int c);
        return fm[r][c];
    endfunction

    // Reference: centre (i,j) against its two neighbours along the gradient direction
    function automatic int ref_pix(int i, int j);
        int dr, dc, m;
        bit k;
        if (i == 0 || j == 0) return 0;
        case (fd[i][j])
            0:       begin dr = 0;  dc = 1;  end
            2:       begin dr = 1;  dc = 0;  end
            1:       begin dr = -1; dc = 1;  end
            default: begin dr = -1; dc = -1; end
        endcase
        m = fm[i][j];
        k = (m >= mag_at(i + dr, j + dc)) && (m >= mag_at(i - dr, j - dc));
`ifdef NMS_LOW_THRESH_EN
        if (m < 20) k = 1'b0;
`endif
        return k ? m : 0;
    endfunction

    task automatic build_frame(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    0: begin fm[r][c] = 50; fd[r][c] = 0; end
                    1: begin fm[r][c] = (c == 4) ? 100 : 40; fd[r][c] = 0; end
                    2: begin fm[r][c] = (c == 4) ? 100 : 40; fd[r][c] = 2; end
                    3, 4: begin
                        fm[r][c] = 10;
                        fd[r][c] = (kind == 3) ? 1 : 3;
                        if (r == 3 && c == 3) fm[r][c] = 90;
                        if (r == 2 && c == 4) fm[r][c] = 95;
                    end
                    6: begin fm[r][c] = 15; fd[r][c] = 0; end
                    default: begin
                        fm[r][c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                                               : int'($urandom_range(30, 33));
                        fd[r][c] = int'($urandom_range(0, 3));
                    end
                endcase
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        valid_in = 1'b1;
        din = 10'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_dout", int'(dout), 0);
        rst = 1'b0;
        valid_in = 1'b0;
        got.delete();
    endtask

    task automatic drive_frame(input int npix, input bit gaps);
        int r, c;
        @(posedge clk); #1;
        for (int k = 0; k < npix; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid_in = 1'b0;
                din = 10'($urandom);
                repeat (int'($urandom_range(1, 3))) begin
                    @(posedge clk); #1;
                end
            end
            r = k / 8;
            c = k % 8;
            valid_in = 1'b1;
            din = {8'(fm[r][c]), 2'(fd[r][c])};
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_count"}, got.size(), NO * NO);
        n = (got.size() < NO * NO) ? got.size() : NO * NO;
        for (int idx = 0; idx < n; idx++)
            check($sformatf("%s_px%0d_%0d", tag, idx / NO, idx % NO), got[idx], ref_pix(idx / NO, idx % NO));
    endtask

    initial begin
        tbl.push_back('{0, 0, 3, 0});   tbl.push_back('{0, 3, 0, 0});
        tbl.push_back('{0, 1, 1, 50});  tbl.push_back('{0, 4, 4, 50});
        tbl.push_back('{0, 6, 6, 50});
        tbl.push_back('{1, 2, 4, 100}); tbl.push_back('{1, 2, 3, 0});
        tbl.push_back('{1, 2, 5, 0});   tbl.push_back('{1, 2, 2, 40});
        tbl.push_back('{1, 0, 4, 0});
        tbl.push_back('{2, 2, 4, 100}); tbl.push_back('{2, 2, 3, 40});
        tbl.push_back('{2, 5, 6, 40});  tbl.push_back('{2, 4, 0, 0});
        tbl.push_back('{3, 3, 3, 0});   tbl.push_back('{4, 3, 3, 90});

        repeat (2) @(posedge clk);
        #1;
        check("initial_valid_out", int'(valid_out), 0);
        check("initial_dout", int'(dout), 0);

        for (int kind = 0; kind <= 4; kind++) begin
            build_frame(kind);
            do_reset();
            drive_frame(NPIX, 1'b0);
            compare_frame($sformatf("kind%0d", kind));
            for (int t = 0; t < tbl.size(); t++)
                if (tbl[t].kind == kind && got.size() == NO * NO)
                    check($sformatf("tbl%0d", t), got[tbl[t].pr * NO + tbl[t].pc], tbl[t].expv);
        end

        // dout must hold the last emitted value once valid_out drops
        check("hold_valid_out", int'(valid_out), 0);
        if (got.size() > 0)
            check("hold_dout", int'(dout), got[got.size() - 1]);

        // back-to-back frames without reset: second frame reuses the line buffers
        build_frame(5);
        got.delete();
        drive_frame(NPIX, 1'b0);
        compare_frame("b2b");

        // stalls: gap run must equal the gap-free run
        for (int rep = 0; rep < 3; rep++) begin
            build_frame(5);
            do_reset();
            drive_frame(NPIX, 1'b0);
            saved = got;
            do_reset();
            drive_frame(NPIX, 1'b1);
            compare_frame($sformatf("gap%0d", rep));
            check($sformatf("gap%0d_len", rep), got.size(), saved.size());
            for (int i = 0; i < got.size() && i < saved.size(); i++)
                check($sformatf("gap%0d_eq%0d", rep, i), got[i], saved[i]);
        end

        // reset mid-frame, after pixel (3,5)
        build_frame(5);
        do_reset();
        drive_frame(3 * 8 + 6, 1'b0);
        build_frame(5);
        do_reset();
        drive_frame(NPIX, 1'b1);
        compare_frame("midrst");

        // low-magnitude surviving pixel
        build_frame(6);
        do_reset();
        drive_frame(NPIX, 1'b0);
        if (got.size() == NO * NO) begin
`ifdef NMS_LOW_THRESH_EN
            check("thresh_mag15", got[3 * NO + 3], 0);
`else
            check("thresh_mag15", got[3 * NO + 3], 15);
`endif
        end else begin
            check("thresh_count", got.size(), NO * NO);
        end
        compare_frame("flat15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
